// File: rtl/waifu_rom_arb.sv
// Single-port portrait ROM arbiter: display port D has absolute priority and fixed
// latency; port B uses valid/ready with a credit-limited in-order response FIFO.
module waifu_rom_arb #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 24,
  parameter int ROM_LAT    = 1,
  parameter int RSP_DEPTH  = 4,
  parameter int STARVE_LIM = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              b_req_valid,
  input  logic [ADDR_W-1:0] b_req_addr,
  output logic              b_req_ready,
  output logic              b_rsp_valid,
  output logic [DATA_W-1:0] b_rsp_data,
  input  logic              b_rsp_ready,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              b_starved
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int IW = $clog2(ROM_LAT + 1);
  localparam int SW = CW + 1;
  localparam int WW = $clog2(STARVE_LIM + 1);

  logic [ROM_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [ROM_LAT-1:0] own_b_q, own_b_d;
  logic [IW-1:0]      inflight_b;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]  mem_q [RSP_DEPTH];
  logic [WW-1:0]      wait_q, wait_d;
  logic               starved_q, starved_d;
  logic               credit_ok, accept, push, pop;

  always_comb begin
    inflight_b = '0;
    for (int i = 0; i < ROM_LAT; i++)
      inflight_b = inflight_b + IW'(vld_pipe_q[i] & own_b_q[i]);
  end

  // Credits count every B read not yet popped: in the tag pipe or in the FIFO.
  assign credit_ok   = (SW'(inflight_b) + SW'(fifo_cnt_q)) < SW'(RSP_DEPTH);
  assign b_req_ready = reset_n & ~disp_req & b_req_valid & credit_ok;
  assign accept      = b_req_valid & b_req_ready;

  always_comb begin
    rom_addr = '0;
    if (reset_n) begin
      if (disp_req)         rom_addr = disp_addr;
      else if (b_req_valid) rom_addr = b_req_addr;
    end
  end

  assign disp_valid  = vld_pipe_q[ROM_LAT-1] & ~own_b_q[ROM_LAT-1];
  assign disp_data   = disp_valid ? rom_q : '0;
  assign push        = vld_pipe_q[ROM_LAT-1] & own_b_q[ROM_LAT-1];
  assign b_rsp_valid = fifo_cnt_q != '0;
  assign b_rsp_data  = b_rsp_valid ? mem_q[rd_ptr_q] : '0;
  assign pop         = b_rsp_valid & b_rsp_ready;
  assign b_starved   = starved_q;

  always_comb begin
    vld_pipe_d    = '0;
    own_b_d       = '0;
    vld_pipe_d[0] = disp_req | accept;
    own_b_d[0]    = ~disp_req;
    for (int i = 1; i < ROM_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      own_b_d[i]    = own_b_q[i-1];
    end
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    wait_d     = wait_q;
    if (accept)
      wait_d = '0;
    else if (b_req_valid && !b_req_ready && wait_q != WW'(STARVE_LIM))
      wait_d = wait_q + WW'(1);
    starved_d = starved_q | (wait_d == WW'(STARVE_LIM));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      own_b_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wait_q     <= '0;
      starved_q  <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      own_b_q    <= own_b_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wait_q     <= wait_d;
      starved_q  <= starved_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rom_q;
  end

  // The credit check makes a push into a full FIFO without a pop unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && fifo_cnt_q == CW'(RSP_DEPTH)));

endmodule

// File: tb/tb_waifu_rom_arb.sv
// Directed + randomized bench for waifu_rom_arb against a queue-based reference model.
module tb_waifu_rom_arb;
  localparam int ADDR_W = 17, DATA_W = 24, ROM_LAT = 1, RSP_DEPTH = 4, STARVE_LIM = 1024;

  logic clk = 1'b0, reset_n;
  logic disp_req, disp_valid, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_starved;
  logic [ADDR_W-1:0] disp_addr, b_req_addr, rom_addr;
  logic [DATA_W-1:0] disp_data, b_rsp_data, rom_q;

  waifu_rom_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT),
                  .RSP_DEPTH(RSP_DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .reset_n(reset_n), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data), .b_req_valid(b_req_valid),
    .b_req_addr(b_req_addr), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
    .b_rsp_data(b_rsp_data), .b_rsp_ready(b_rsp_ready), .rom_addr(rom_addr),
    .rom_q(rom_q), .b_starved(b_starved));

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] romf(input logic [ADDR_W-1:0] a);
    return {a[7:0] ^ 8'hA5, a[16:1]};
  endfunction

  // ROM behavioural model with ROM_LAT clocks of read latency
  logic [DATA_W-1:0] rq [ROM_LAT];
  always @(posedge clk) begin
    rq[0] <= romf(rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign rom_q = rq[ROM_LAT-1];

  typedef struct { int cyc; logic [DATA_W-1:0] d; } dexp_t;
  typedef struct { int rdy; logic [ADDR_W-1:0] a; } bexp_t;
  dexp_t dq[$];
  bexp_t bq[$];
  int    cyc = 0, m_wait = 0;
  logic  m_starved = 1'b0, last_acc = 1'b0;
  int    errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock: compare outputs mid-cycle, then advance the model past the edge.
  task automatic tick();
    logic exp_ready, exp_dv, exp_rv, acc, pop;
    logic [ADDR_W-1:0] ea;
    acc = 1'b0; pop = 1'b0; exp_ready = 1'b0;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_b_req_ready", 32'(b_req_ready), 32'd0);
      chk("rst_disp_valid", 32'(disp_valid), 32'd0);
      chk("rst_disp_data", 32'(disp_data), 32'd0);
      chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
      chk("rst_b_rsp_data", 32'(b_rsp_data), 32'd0);
      chk("rst_b_starved", 32'(b_starved), 32'd0);
    end else begin
      ea = disp_req ? disp_addr : (b_req_valid ? b_req_addr : '0);
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      exp_ready = !disp_req && b_req_valid && (bq.size() < RSP_DEPTH);
      chk("b_req_ready", 32'(b_req_ready), 32'(exp_ready));
      exp_dv = (dq.size() > 0) && (dq[0].cyc == cyc);
      chk("disp_valid", 32'(disp_valid), 32'(exp_dv));
      if (exp_dv) begin
        chk("disp_data", 32'(disp_data), 32'(dq[0].d));
        void'(dq.pop_front());
      end
      exp_rv = (bq.size() > 0) && (bq[0].rdy <= cyc);
      chk("b_rsp_valid", 32'(b_rsp_valid), 32'(exp_rv));
      if (exp_rv) chk("b_rsp_data", 32'(b_rsp_data), 32'(romf(bq[0].a)));
      chk("b_starved", 32'(b_starved), 32'(m_starved));
      acc = b_req_valid && exp_ready;
      pop = exp_rv && b_rsp_ready;
    end
    @(posedge clk); #1;
    if (!reset_n) begin
      dq.delete(); bq.delete(); m_wait = 0; m_starved = 1'b0;
    end else begin
      if (pop) void'(bq.pop_front());
      if (acc) bq.push_back('{rdy: cyc + ROM_LAT + 1, a: b_req_addr});
      if (disp_req) dq.push_back('{cyc: cyc + ROM_LAT, d: romf(disp_addr)});
      if (acc) m_wait = 0;
      else if (b_req_valid && !exp_ready && m_wait < STARVE_LIM) m_wait++;
      if (m_wait == STARVE_LIM) m_starved = 1'b1;
    end
    last_acc = acc;
    cyc++;
  endtask

  task automatic b_send(input logic [ADDR_W-1:0] a, input int lim);
    int n;
    n = 0;
    b_req_valid = 1'b1; b_req_addr = a;
    do begin tick(); n++; end while (!last_acc && n < lim);
    if (!last_acc) begin
      checks++; errors++;
      $error("FAIL b_send_timeout addr=%0h observed=no_accept expected=accept", a);
    end
    b_req_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_rsp_ready = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // T1: display burst, B idle
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'(i); tick();
    end
    disp_req = 1'b0;
    repeat (3) tick();

    // T2: four B reads back to back
    b_rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) b_send(17'h100 + ADDR_W'(i), 1);
    repeat (4) tick();

    // T3: collision, display wins
    disp_req = 1'b1; disp_addr = 17'd5; b_req_valid = 1'b1; b_req_addr = 17'h20;
    tick();
    chk("t3_ready_blocked", 32'(b_req_ready), 32'd0);
    disp_req = 1'b0;
    b_send(17'h20, 1);
    repeat (3) tick();

    // T4: credit exhaustion with consumer stalled
    b_rsp_ready = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++) b_send(17'h300 + ADDR_W'(i), 3);
    b_req_valid = 1'b1; b_req_addr = 17'h3AA;
    repeat (4) tick();
    chk("t4_full_no_ready", 32'(b_req_ready), 32'd0);
    b_rsp_ready = 1'b1; tick();
    b_rsp_ready = 1'b0; tick();
    repeat (3) tick();
    b_req_valid = 1'b0; b_rsp_ready = 1'b1;
    repeat (8) tick();

    // T5: starvation under continuous display traffic
    b_req_valid = 1'b1; b_req_addr = 17'h55;
    for (int i = 0; i < 1100; i++) begin
      disp_req = 1'b1; disp_addr = ADDR_W'($urandom_range(0, 2**ADDR_W - 1)); tick();
    end
    chk("t5_starved_set", 32'(b_starved), 32'd1);
    disp_req = 1'b0;
    b_send(17'h55, 2);
    repeat (3) tick();
    chk("t5_starved_sticky", 32'(b_starved), 32'd1);

    // Randomized traffic, B address held while waiting
    for (int i = 0; i < 400; i++) begin
      disp_req = ($urandom_range(0, 2) == 0);
      disp_addr = ADDR_W'($urandom);
      if (!(b_req_valid && !last_acc)) begin
        b_req_valid = ($urandom_range(0, 1) == 1);
        b_req_addr = ADDR_W'($urandom);
      end
      b_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    disp_req = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b1;
    repeat (8) tick();

    // T6: reset with reads in flight and a part-full FIFO
    b_rsp_ready = 1'b0;
    for (int i = 0; i < RSP_DEPTH; i++) b_send(17'h600 + ADDR_W'(i), 3);
    b_req_valid = 1'b1; b_req_addr = 17'h6FF; disp_req = 1'b1; disp_addr = 17'h42;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1; disp_req = 1'b0; b_req_valid = 1'b0; b_rsp_ready = 1'b1;
    repeat (4) tick();
    chk("t6_no_stale_rsp", 32'(b_rsp_valid), 32'd0);
    b_send(17'h777, 2);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
